lcd_show_window: RTL and testbench
==================================

// Module: lcd_show_window
// PURPOSE
//  Parametrised successor of the single-row LCD painter. It draws an arbitrary
//  rectangle (x0,y0,width,height) of ROM-stored pixels onto the ST7789-style panel.
//  It issues CASET (0x2A), RASET (0x2B) and RAMWR (0x2C), then streams width*height*BPP_BYTES
//  pixel bytes from ROM. It sits between the display top FSM and the SPI byte writer.
// PARAMETERS
//  COORD_W    9    width of x0/y0/width/height inputs (zero-extended to 16b in commands)
//  MAX_W      320  panel columns; the window must satisfy x0+width  <= MAX_W
//  MAX_H      480  panel rows;    the window must satisfy y0+height <= MAX_H
//  BPP_BYTES  2    bytes per pixel (1..4)
//  ADDR_W     19   ROM byte-address width
//  ROM_LAT    2    ROM read latency in cycles (rom_addr -> rom_q), 1..4
// PORTS
//  sys_clk    in  1        clock
//  sys_rst    in  1        synchronous reset, active-high
//  start      in  1        1-cycle request; ignored unless the block is idle
//  abort      in  1        cancel the current job
//  x0,y0      in  COORD_W  window origin, latched on start
//  width      in  COORD_W  window columns, latched on start
//  height     in  COORD_W  window rows, latched on start
//  rom_base   in  ADDR_W   first pixel byte address, latched on start
//  rom_addr   out ADDR_W   ROM read address
//  rom_q      in  8        ROM data, valid ROM_LAT cycles after rom_addr
//  wr_valid   out 1        wr_data holds a word for the SPI writer
//  wr_data    out 9        {dc,byte}: dc=0 means command, dc=1 means data
//  wr_done    in  1        1-cycle pulse: the writer has consumed the current word
//  busy       out 1        high from the cycle after an accepted start until done
//  done       out 1        1-cycle completion pulse
//  err        out 1        qualifies done: job rejected or aborted; held until next start
// BEHAVIOUR
//  Reset: state IDLE. rom_addr, wr_valid, wr_data, busy, done and err are all 0.
//   Reset mid-job drops wr_valid on the next edge and discards the job.
//  States: IDLE -> CMD -> FETCH <-> PIXEL -> DONE -> IDLE.
//   CMD sends 11 words in order:
//    02A, 1_x0[15:8], 1_x0[7:0], 1_x1[15:8], 1_x1[7:0],
//    02B, 1_y0[15:8], 1_y0[7:0], 1_y1[15:8], 1_y1[7:0], 02C.
//   x1 = x0+width-1 and y1 = y0+height-1, computed in 16b.
//  Start: start accepted in cycle N gives busy=1, wr_valid=1, wr_data=0x02A in cycle N+1.
//  Validation: checked on start. If width==0, height==0, or the window exceeds MAX_W/MAX_H:
//   no word is written; done=1 and err=1 in N+1; back to IDLE in N+2.
//  Handshake: wr_data is stable while wr_valid=1.
//   On wr_done, wr_valid drops in the next cycle.
//   A wr_done while wr_valid=0 is ignored.
//  CMD: the next command word is presented 1 cycle after wr_done (1-cycle gap).
//  FETCH: rom_addr = rom_base + byte_cnt is driven, then the FSM waits ROM_LAT cycles.
//   It then registers {1'b1, rom_q} onto wr_data with wr_valid=1 (state PIXEL).
//  PIXEL: on wr_done, byte_cnt increments.
//   If byte_cnt == total-1, go to DONE; otherwise go to FETCH.
//   total = width*height*BPP_BYTES, computed in ADDR_W bits, with no wrap inside a job.
//  DONE: done=1 and busy=0 for exactly one cycle, then IDLE. rom_addr holds its last value.
//  Abort: in any busy state, the next cycle is DONE with err=1 and wr_valid=0.
//   A word already on the bus is abandoned; the writer must tolerate this.
//   If abort and wr_done coincide, abort wins.
//  Simultaneous events: start in the same cycle as done is ignored.
//   start together with abort while idle: start wins, and that abort is ignored.
//  Byte order per pixel: ROM order, MSB first. No reordering is done.
// TESTING
//  T1: x0=0,y0=0,w=1,h=1, writer acks 3 cycles after each valid.
//   -> 11 cmd words (02A,100,100,100,100,02B,100,100,100,100,02C),
//      then 2 data bytes from rom_base and rom_base+1, then done with err=0.
//  T2: x0=100,y0=300,w=20,h=10,BPP=2.
//   -> x1=0x077, y1=0x135 encoded correctly; exactly 400 data words;
//      last rom_addr = rom_base+399.
//  T3: w=0, or x0=310 with w=20.
//   -> no wr_valid ever; done=err=1 one cycle after start.
//  T4: abort during PIXEL at byte 57.
//   -> next cycle done=err=1, wr_valid=0; a following start runs cleanly.
//  T5: sys_rst asserted during CMD word 6.
//   -> all outputs 0 on the next edge; start after reset begins at 0x02A.
//  T6: start pulsed while busy, and wr_done pulsed while wr_valid=0.
//   -> both ignored; word count and rom_addr sequence are unchanged.

Source files
------------

// File: rtl/lcd_show_window.sv
// rtl/lcd_show_window.sv - paints a ROM-backed rectangle onto an ST7789-style panel
//
// Sends CASET/RASET/RAMWR for the window (x0,y0)-(x0+width-1,y0+height-1), then
// streams width*height*BPP_BYTES pixel bytes read from ROM starting at rom_base.
//
// Ports:
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   start, abort                job request (idle only) / cancel running job
//   x0, y0, width, height       window geometry, latched on an accepted start
//   rom_base                    first pixel byte address, latched on start
//   rom_addr, rom_q             ROM read port (rom_q valid ROM_LAT cycles later)
//   wr_valid, wr_data, wr_done  word handshake to the SPI writer, wr_data = {dc,byte}
//   busy, done, err             job status; err qualifies done and holds until next start
module lcd_show_window #(
    parameter int COORD_W   = 9,
    parameter int MAX_W     = 320,
    parameter int MAX_H     = 480,
    parameter int BPP_BYTES = 2,
    parameter int ADDR_W    = 19,
    parameter int ROM_LAT   = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic [ADDR_W-1:0]  rom_base,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_q,
    output logic               wr_valid,
    output logic [8:0]         wr_data,
    input  logic               wr_done,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PROD_W = 2 * COORD_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FETCH,
        S_PIXEL,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [15:0]         x0_q, y0_q, x1_q, y1_q;
    logic [ADDR_W-1:0]   rom_base_q, total_q, byte_cnt_q, rom_addr_q;
    logic [3:0]          cmd_idx_q;
    logic [2:0]          wait_q;
    logic                wr_valid_q, busy_q, done_q, err_q;
    logic [8:0]          wr_data_q;

    logic [16:0]         x_end_d, y_end_d;
    logic [PROD_W-1:0]   prod_d;
    logic [ADDR_W-1:0]   total_d;
    logic                reject_d;
    logic [8:0]          cmd_word_d;

    always_comb begin
        x_end_d  = 17'(x0) + 17'(width);
        y_end_d  = 17'(y0) + 17'(height);
        reject_d = (width == '0) || (height == '0) ||
                   (x_end_d > 17'(MAX_W)) || (y_end_d > 17'(MAX_H));
        prod_d   = PROD_W'(width) * PROD_W'(height) * PROD_W'(BPP_BYTES);
        total_d  = ADDR_W'(prod_d);
        cmd_word_d = 9'h000;
        case (cmd_idx_q)
            4'd0:    cmd_word_d = 9'h02A;
            4'd1:    cmd_word_d = {1'b1, x0_q[15:8]};
            4'd2:    cmd_word_d = {1'b1, x0_q[7:0]};
            4'd3:    cmd_word_d = {1'b1, x1_q[15:8]};
            4'd4:    cmd_word_d = {1'b1, x1_q[7:0]};
            4'd5:    cmd_word_d = 9'h02B;
            4'd6:    cmd_word_d = {1'b1, y0_q[15:8]};
            4'd7:    cmd_word_d = {1'b1, y0_q[7:0]};
            4'd8:    cmd_word_d = {1'b1, y1_q[15:8]};
            4'd9:    cmd_word_d = {1'b1, y1_q[7:0]};
            4'd10:   cmd_word_d = 9'h02C;
            default: cmd_word_d = 9'h000;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            rom_base_q <= '0;
            total_q    <= '0;
            byte_cnt_q <= '0;
            rom_addr_q <= '0;
            cmd_idx_q  <= '0;
            wait_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q == S_CMD || state_q == S_FETCH || state_q == S_PIXEL)) begin
                // Any word on the bus is abandoned; abort outranks a coincident wr_done.
                state_q    <= S_DONE;
                wr_valid_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                err_q      <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            x0_q       <= 16'(x0);
                            y0_q       <= 16'(y0);
                            x1_q       <= 16'(x0) + 16'(width) - 16'd1;
                            y1_q       <= 16'(y0) + 16'(height) - 16'd1;
                            rom_base_q <= rom_base;
                            total_q    <= total_d;
                            byte_cnt_q <= '0;
                            err_q      <= reject_d;
                            if (reject_d) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= S_CMD;
                                busy_q     <= 1'b1;
                                wr_valid_q <= 1'b1;
                                wr_data_q  <= 9'h02A;
                                cmd_idx_q  <= 4'd0;
                            end
                        end
                    end
                    S_CMD: begin
                        if (wr_valid_q && wr_done) begin
                            wr_valid_q <= 1'b0;
                            if (cmd_idx_q == 4'd10) begin
                                state_q    <= S_FETCH;
                                rom_addr_q <= rom_base_q;
                                wait_q     <= '0;
                            end else begin
                                cmd_idx_q <= cmd_idx_q + 4'd1;
                            end
                        end else if (!wr_valid_q) begin
                            // Gap cycle after an ack: present the next command word.
                            wr_valid_q <= 1'b1;
                            wr_data_q  <= cmd_word_d;
                        end
                    end
                    S_FETCH: begin
                        // rom_addr was set on entry, so rom_q is valid once wait_q reaches ROM_LAT.
                        if (wait_q == 3'(ROM_LAT)) begin
                            state_q    <= S_PIXEL;
                            wr_valid_q <= 1'b1;
                            wr_data_q  <= {1'b1, rom_q};
                        end else begin
                            wait_q <= wait_q + 3'd1;
                        end
                    end
                    S_PIXEL: begin
                        if (wr_done) begin
                            wr_valid_q <= 1'b0;
                            if (byte_cnt_q == total_q - ADDR_W'(1)) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= S_FETCH;
                                byte_cnt_q <= byte_cnt_q + ADDR_W'(1);
                                rom_addr_q <= rom_base_q + byte_cnt_q + ADDR_W'(1);
                                wait_q     <= '0;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lcd_show_window.sv
// tb/tb_lcd_show_window.sv - self-checking bench for lcd_show_window
module tb_lcd_show_window;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  x0 = '0, y0 = '0, width = '0, height = '0;
    logic [18:0] rom_base = '0;
    logic [18:0] rom_addr;
    logic [7:0]  rom_q;
    logic        wr_valid;
    logic [8:0]  wr_data;
    logic        wr_done = 1'b0;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    lcd_show_window dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .width(width), .height(height), .rom_base(rom_base),
        .rom_addr(rom_addr), .rom_q(rom_q), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_done(wr_done), .busy(busy), .done(done), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] rom_f(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Two-stage ROM pipeline: data appears two cycles after the address.
    logic [7:0] pipe0, pipe1;
    always @(posedge sys_clk) begin
        pipe0 <= rom_f(rom_addr);
        pipe1 <= pipe0;
    end
    assign rom_q = pipe1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  x0, y0, w, h;
        logic [18:0] base;
        int          ack;
        bit          eerr;
        logic [15:0] x1, y1;
        int          n;
        int          abort_at;
        bit          noise;
    } vec_t;

    vec_t tv[9];

    task automatic run_job(input vec_t v);
        logic [8:0]  wds[$];
        logic [18:0] adrs[$];
        logic [8:0]  ec[11];
        logic [15:0] xs, ys;
        int cnt, bad, first;
        bit fin;
        logic [31:0] ba, be;
        x0 = v.x0; y0 = v.y0; width = v.w; height = v.h; rom_base = v.base;
        start = 1'b1;
        @(posedge sys_clk); #1;
        if (v.noise) begin
            x0 = 9'd0; width = 9'd0; height = 9'd0; rom_base = 19'h7FFFF;
        end else begin
            start = 1'b0;
        end
        if (v.eerr && v.abort_at < 0) begin
            chk(done === 1'b1 && err === 1'b1 && wr_valid === 1'b0 && busy === 1'b0,
                "reject_n1", {done, err, wr_valid, busy}, 4'b1100);
            @(posedge sys_clk); #1;
            chk(done === 1'b0 && err === 1'b1 && wr_valid === 1'b0 && busy === 1'b0,
                "reject_n2", {done, err, wr_valid, busy}, 4'b0100);
            return;
        end
        chk(busy === 1'b1 && wr_valid === 1'b1 && done === 1'b0 && wr_data === 9'h02A,
            "start_latency", {busy, wr_valid, done, wr_data}, {3'b110, 9'h02A});
        cnt = 0; fin = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (wr_done || abort) begin
                wr_done = 1'b0; abort = 1'b0;
            end else if (wr_valid) begin
                if (cnt >= v.ack) begin
                    cnt = 0;
                    if (v.abort_at >= 0 && wds.size() == 11 + v.abort_at) begin
                        abort = 1'b1; wr_done = 1'b1;
                    end else begin
                        wds.push_back(wr_data); adrs.push_back(rom_addr); wr_done = 1'b1;
                    end
                end else begin
                    cnt++;
                end
            end else if (v.noise) begin
                wr_done = 1'b1;
            end
            @(posedge sys_clk); #1;
            if (done) begin fin = 1'b1; break; end
        end
        start = 1'b0; abort = 1'b0; wr_done = 1'b0;
        chk(fin, "done_timeout", {31'd0, fin}, 32'd1);
        chk(done === 1'b1 && busy === 1'b0 && err === v.eerr && wr_valid === 1'b0,
            "done_flags", {done, busy, err, wr_valid}, {2'b10, v.eerr, 1'b0});
        chk(wds.size() == 11 + v.n, "word_count", wds.size(), 11 + v.n);
        xs = 16'(v.x0); ys = 16'(v.y0);
        ec = '{9'h02A, {1'b1, xs[15:8]}, {1'b1, xs[7:0]}, {1'b1, v.x1[15:8]}, {1'b1, v.x1[7:0]},
               9'h02B, {1'b1, ys[15:8]}, {1'b1, ys[7:0]}, {1'b1, v.y1[15:8]}, {1'b1, v.y1[7:0]},
               9'h02C};
        bad = 0; first = -1; ba = 0; be = 0;
        for (int i = 0; i < 11; i++) begin
            if (i >= wds.size() || wds[i] !== ec[i]) begin
                if (first < 0) begin first = i; ba = (i < wds.size()) ? 32'(wds[i]) : 32'hFFFF; be = 32'(ec[i]); end
                bad++;
            end
        end
        chk(bad == 0, "cmd_words", ba, be);
        bad = 0; first = -1; ba = 0; be = 0;
        for (int i = 0; i < v.n; i++) begin
            if (11 + i >= wds.size() || wds[11+i] !== {1'b1, rom_f(v.base + 19'(i))}) begin
                if (first < 0) begin first = i; ba = (11 + i < wds.size()) ? 32'(wds[11+i]) : 32'hFFFF; be = 32'({1'b1, rom_f(v.base + 19'(i))}); end
                bad++;
            end
        end
        chk(bad == 0, "data_words", ba, be);
        bad = 0; first = -1; ba = 0; be = 0;
        for (int i = 0; i < v.n; i++) begin
            if (11 + i >= adrs.size() || adrs[11+i] !== v.base + 19'(i)) begin
                if (first < 0) begin first = i; ba = (11 + i < adrs.size()) ? 32'(adrs[11+i]) : 32'hFFFFF; be = 32'(v.base + 19'(i)); end
                bad++;
            end
        end
        chk(bad == 0, "rom_addr_seq", ba, be);
        @(posedge sys_clk); #1;
        chk(done === 1'b0 && busy === 1'b0 && wr_valid === 1'b0, "idle_after",
            {done, busy, wr_valid}, 3'b000);
    endtask

    initial begin
        int n;
        bit hit;
        //         x0      y0      w       h      base       ack err x1        y1        n    abort noise
        tv[0] = '{9'd0,   9'd0,   9'd1,   9'd1,  19'h00100, 3, 1'b0, 16'h0000, 16'h0000, 2,   -1, 1'b0};
        tv[1] = '{9'd100, 9'd300, 9'd20,  9'd10, 19'h02000, 0, 1'b0, 16'h0077, 16'h0135, 400, -1, 1'b0};
        tv[2] = '{9'd5,   9'd5,   9'd0,   9'd4,  19'h00000, 0, 1'b1, 16'h0000, 16'h0000, 0,   -1, 1'b0};
        tv[3] = '{9'd310, 9'd0,   9'd20,  9'd1,  19'h00000, 0, 1'b1, 16'h0000, 16'h0000, 0,   -1, 1'b0};
        tv[4] = '{9'd300, 9'd470, 9'd20,  9'd10, 19'h7FE00, 1, 1'b0, 16'h013F, 16'h01DF, 400, -1, 1'b0};
        tv[5] = '{9'd0,   9'd475, 9'd1,   9'd6,  19'h00000, 0, 1'b1, 16'h0000, 16'h0000, 0,   -1, 1'b0};
        tv[6] = '{9'd100, 9'd300, 9'd20,  9'd10, 19'h00040, 1, 1'b1, 16'h0077, 16'h0135, 57,  57, 1'b0};
        tv[7] = '{9'd2,   9'd3,   9'd3,   9'd2,  19'h00055, 2, 1'b0, 16'h0004, 16'h0004, 12,  -1, 1'b1};
        tv[8] = '{9'd1,   9'd1,   9'd4,   9'd0,  19'h00000, 0, 1'b1, 16'h0000, 16'h0000, 0,   -1, 1'b0};

        @(posedge sys_clk); @(posedge sys_clk); #1;
        chk(rom_addr === '0 && wr_valid === 1'b0 && wr_data === '0 && busy === 1'b0 &&
            done === 1'b0 && err === 1'b0, "reset_state",
            {rom_addr, wr_valid, busy, done, err}, 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        for (int i = 0; i < 9; i++) run_job(tv[i]);

        // Reset while the sixth command word (0x02B) is on the bus.
        x0 = 9'd7; y0 = 9'd8; width = 9'd2; height = 9'd2; rom_base = 19'h00300;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        n = 0; hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (wr_done) begin
                wr_done = 1'b0;
            end else if (wr_valid) begin
                if (n == 5) begin hit = 1'b1; break; end
                n++;
                wr_done = 1'b1;
            end
            @(posedge sys_clk); #1;
        end
        chk(hit && wr_data === 9'h02B, "t5_word6", {23'd0, wr_data}, 32'h02B);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        chk(rom_addr === '0 && wr_valid === 1'b0 && wr_data === '0 && busy === 1'b0 &&
            done === 1'b0 && err === 1'b0, "t5_reset_outputs",
            {rom_addr, wr_valid, busy, done, err}, 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        run_job(tv[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
